// File: rtl/bcd_updown_counter_pkg.sv
// Shared digit-level types and constants for the BCD up/down counter.
// Optional parallel load is controlled by BCD_CNT_LOAD_EN.
package bcd_cnt_pkg;

    localparam int              DIGIT_W   = 4;
    localparam logic [3:0]      DIGIT_MAX = 4'd9;
    localparam logic [3:0]      DIGIT_MIN = 4'd0;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    function automatic bcd_digit_t clamp_digit(input bcd_digit_t d);
        return (d > DIGIT_MAX) ? DIGIT_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Control/status bundle between a controller (master) and the counter (slave).
// load, load_val and load_err exist only when BCD_CNT_LOAD_EN is defined.
interface bcd_updown_counter_if #(
    parameter int DIGITS = 3
);
    logic                  en;
    logic                  up;
    logic [4*DIGITS-1:0]   count;
    logic                  done;
    logic                  wrap;
`ifdef BCD_CNT_LOAD_EN
    logic                  load;
    logic [4*DIGITS-1:0]   load_val;
    logic                  load_err;

    modport master (output en, up, load, load_val,
                    input  count, done, wrap, load_err);
    modport slave  (input  en, up, load, load_val,
                    output count, done, wrap, load_err);
`else
    modport master (output en, up,
                    input  count, done, wrap);
    modport slave  (input  en, up,
                    output count, done, wrap);
`endif
endinterface

// File: rtl/bcd_updown_counter_decade_cell.sv
// One BCD decade: steps its digit when cin is set and ripples carry/borrow out.
// Purely combinational; the caller owns the digit register.
module bcd_decade_cell
    import bcd_cnt_pkg::*;
(
    input  bcd_digit_t digit_i,
    input  logic       cin_i,
    input  logic       up_i,
    output bcd_digit_t digit_o,
    output logic       cout_o
);

    logic at_edge;

    assign at_edge = up_i ? (digit_i == DIGIT_MAX) : (digit_i == DIGIT_MIN);
    assign cout_o  = cin_i & at_edge;

    always_comb begin
        digit_o = digit_i;
        if (cin_i) begin
            if (up_i)
                digit_o = at_edge ? DIGIT_MIN : digit_i + 4'd1;
            else
                digit_o = at_edge ? DIGIT_MAX : digit_i - 4'd1;
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// N-decade BCD up/down counter with wrap or hold at terminal; optional clamped
// parallel load under BCD_CNT_LOAD_EN. One-cycle latency, steps every enabled cycle.
module bcd_updown_counter
    import bcd_cnt_pkg::*;
#(
    parameter int DIGITS     = 3,
    parameter bit STOP_AT_TC = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    bcd_updown_counter_if.slave  bus
);

    localparam int W = DIGIT_W * DIGITS;

    logic [W-1:0]    count_q, count_d, step_val;
    logic [DIGITS:0] carry;
    logic            at_tc;
    logic            wrap_q, wrap_d;

    // Injecting a carry into digit 0 makes the final carry-out the terminal detect.
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_cell
        bcd_decade_cell u_cell (
            .digit_i (count_q[DIGIT_W*g +: DIGIT_W]),
            .cin_i   (carry[g]),
            .up_i    (bus.up),
            .digit_o (step_val[DIGIT_W*g +: DIGIT_W]),
            .cout_o  (carry[g+1])
        );
    end

    assign at_tc = carry[DIGITS];

`ifdef BCD_CNT_LOAD_EN
    logic [W-1:0] load_clamped;
    logic         clamp_any;
    logic         load_err_q, load_err_d;

    always_comb begin
        load_clamped = '0;
        clamp_any    = 1'b0;
        for (int g = 0; g < DIGITS; g++) begin
            load_clamped[DIGIT_W*g +: DIGIT_W] = clamp_digit(bus.load_val[DIGIT_W*g +: DIGIT_W]);
            if (bus.load_val[DIGIT_W*g +: DIGIT_W] > DIGIT_MAX)
                clamp_any = 1'b1;
        end
    end
`endif

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
`ifdef BCD_CNT_LOAD_EN
        load_err_d = 1'b0;
        if (bus.load) begin
            count_d    = load_clamped;
            load_err_d = clamp_any;
        end else
`endif
        if (bus.en) begin
            if (!(at_tc && STOP_AT_TC)) begin
                count_d = step_val;
                wrap_d  = at_tc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef BCD_CNT_LOAD_EN
    always_ff @(posedge clk) begin
        if (reset) load_err_q <= 1'b0;
        else       load_err_q <= load_err_d;
    end

    assign bus.load_err = load_err_q;
`endif

    assign bus.count = count_q;
    assign bus.done  = at_tc;
    assign bus.wrap  = wrap_q;

endmodule

// File: doc/bcd_updown_counter.md
# bcd_updown_counter

Parametrised N-decade BCD counter: the successor to the team's fixed three-digit up-counter. Adds configurable digit count, up/down direction, wrap or stop-at-terminal mode, and an optional parallel load. It sits between control logic and display/decoder stages, and is built from a chain of identical single-decade cells.

## Interface
- DIGITS, 3: number of decades (1–8); count width = 4*DIGITS.
- STOP_AT_TC, 0: 0 = wrap at terminal; 1 = hold at terminal.
- clk  in  1  rising-edge clock, single domain.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; one step per cycle while high.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  parallel load strobe (BCD_CNT_LOAD_EN only).
- load_val  in  4*DIGITS  BCD load value, digit 0 in [3:0] (BCD_CNT_LOAD_EN only).
- count  out  4*DIGITS  current BCD value, digit 0 = ones.
- done  out  1  count equals the terminal value for the current direction.
- wrap  out  1  one-cycle pulse on rollover.
- load_err  out  1  one-cycle pulse: load_val held a non-BCD digit (BCD_CNT_LOAD_EN only).

## Operation
- Priority per edge: reset > load > en step > hold.
- Terminal values:
  - Up: all digits 9 (e.g. 999 for DIGITS=3).
  - Down: all digits 0.
- Increment: digit 0 +1. A digit at 9 with carry-in becomes 0 and carries to the next digit. A digit below 9 absorbs the carry.
- Decrement: digit 0 −1. A digit at 0 with borrow-in becomes 9 and borrows from the next digit.
- Step at terminal, STOP_AT_TC=0: count wraps (999→000 up, 000→999 down). wrap=1 in the cycle the wrapped value appears on count.
- Step at terminal, STOP_AT_TC=1: count holds and wrap stays 0. Toggling up leaves the terminal, and counting resumes on the next enabled edge.
- done is combinational from the registered count and current up. A change of up changes done in the same cycle.
- Load: count <= load_val, with any digit >9 clamped to 9. load_err pulses in the following cycle whenever any digit was clamped. Load ignores en. wrap=0 on a load cycle.
- en low: count, wrap and load_err hold/deassert. No step occurs.
- Reset mid-count: count=0 on the next edge. Any pending wrap/load_err pulse is cleared.
- The count register never holds a non-BCD digit.

## Timing
- Reset values:
  - count = 0, wrap = 0, load_err = 0.
  - done = ~up, because 0 is the down terminal.
- Latency: en/load sampled at edge k; the new count is visible after edge k.
- wrap and load_err are registered pulses of exactly one cycle. They are asserted in the same cycle as the corresponding count value.
- Carry/borrow ripple across all DIGITS is combinational within one cycle, so no multi-cycle carry exists.
- Back-to-back steps are supported every cycle. A full wrap period is 10^DIGITS enabled cycles.

## Configuration
- Macro: BCD_CNT_LOAD_EN.
- Defined: the load and load_val inputs and the load_err output exist, and the load path with clamp behaves as above.
- Undefined: those three ports are absent, and the load mux and clamp logic are not synthesised. All other behaviour is identical.

## Structure
- Package bcd_cnt_pkg:
  - DIGIT_W = 4
  - DIGIT_MAX = 4'd9
  - DIGIT_MIN = 4'd0
  - typedef bcd_digit_t (logic [3:0])
- Sub-module bcd_decade_cell:
  - Inputs: one digit register, cin, up.
  - Outputs: next digit, cout.
  - cout is asserted at 9 with cin when up=1, and at 0 with cin when up=0.
  - Instantiated DIGITS times via generate; the top level holds the load/clamp, terminal detect and pulse registers.

## Test plan
- DIGITS=3, wrap mode: reset, then en=1, up=1 for 1000 cycles. count runs 000→999; done=1 exactly at 999; next edge gives count=000 with wrap=1 for one cycle.
- DIGITS=3, up=0 from reset: the first enabled edge gives count=999 with wrap=1. done=1 at reset and deasserts after the step.
- STOP_AT_TC=1, up=1: count held at 999 for 5 extra enabled cycles with wrap=0. Then up=0 gives done=0 immediately and 998 on the next edge.
- Load (macro on): load_val=0x0199, up=1, en=1. Next count = 199, then 200 (multi-digit carry).
  - Load 0x0A5F gives count=959 and load_err=1 for one cycle.
- Priority: load=1 and en=1 together take the load value with no step. reset=1 with load=1 gives count=000.
  - en=0 for 10 cycles mid-count holds the value unchanged.
- DIGITS=1 and DIGITS=6 builds: up wrap at 9→0 and 999999→000000 respectively, each with a single wrap pulse.
